pcie_rx_wr_arb: RTL
===================

# pcie_rx_wr_arb

Arbiter for the shared memory write port of the PCIe receive path. Two requesters issue write beats: the posted-write handler (`wr`, host MMIO writes) and the completion handler (`cm`, DMA read completions). Each requester has its own beat FIFO, so neither side loses writes when both are active. A round-robin scheduler with a burst limit drains the FIFOs onto the single registered memory write interface, and per-requester almost-full flags let the receive logic throttle `trn_rdst_rdy_n`.

## Interface
Parameters:
- `ADDR_W`, default `` `MEM_ADDR_BITS ``: width of `addr_hi` and `addr_lo`.
- `FIFO_DEPTH`, default 8: beats per requester FIFO; power of two, 4 to 32.
- `AFULL_THRESH`, default 6: occupancy at or above which `*_afull` asserts.
- `MAX_BURST`, default 4: maximum consecutive grants to one requester while the other is waiting.

Ports:
- `pcie_clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `wr_if_select_wr` / `_cm`  in  2  interface select for each requester.
- `wr_mem_select_wr` / `_cm`  in  4  memory select.
- `wr_addr_hi_wr` / `_cm`, `wr_addr_lo_wr` / `_cm`  in  ADDR_W  word addresses.
- `wr_data_hi_wr` / `_cm`, `wr_data_lo_wr` / `_cm`  in  32  data.
- `wr_mask_hi_wr` / `_cm`, `wr_mask_lo_wr` / `_cm`  in  4  byte masks.
- `wr_en_hi_wr` / `_cm`, `wr_en_lo_wr` / `_cm`  in  1  lane enables. A beat is valid when `en_hi | en_lo`.
- `wr_afull_wr`, `wr_afull_cm`  out  1  FIFO occupancy ≥ AFULL_THRESH.
- `wr_if_select`, `wr_mem_select`, `wr_addr_hi/lo`, `wr_data_hi/lo`, `wr_mask_hi/lo`, `wr_en_hi/lo`  out  (widths as above)  arbitrated write port.
- `ovf_wr`, `ovf_cm`  out  1  sticky overflow flags.
- `stat_grant_wr`, `stat_grant_cm`, `stat_ovf_cnt`  out  32  statistics counters.

## Operation
- **Beat capture.** A valid beat is pushed into its requester's FIFO as the full beat: all fields, including both enables.
- **Full FIFO.** A push into a full FIFO drops the beat and sets the sticky `ovf_*` flag. Only `rst` clears the flag.
- **Scheduler state.** Holds `grant` (0 = wr, 1 = cm) and a burst counter `bcnt` of clog2(MAX_BURST)+1 bits.
- **Scheduler decision, each cycle:**
  - Both FIFOs empty: no pop.
  - Only one FIFO non-empty: pop it. Set `grant` to it. Set `bcnt` to 1 if `grant` changed, otherwise increment, saturating at MAX_BURST.
  - Both FIFOs non-empty, `grant` side has `bcnt < MAX_BURST`: pop the `grant` side and increment `bcnt`.
  - Both FIFOs non-empty, `bcnt == MAX_BURST`: switch `grant`, pop the new side, set `bcnt` = 1.
- **Output register.** A popped beat is loaded into the output register and `wr_en_hi/lo` take the stored enables. In cycles with no pop, `wr_en_hi/lo` = 0 and all other outputs hold their previous values.
- **Beat integrity.** Beats are never split or reordered within a requester.
- **Reset.** `rst` flushes both FIFOs and zeroes every output, flag and counter on the next edge. It also sets `grant` = 0 and `bcnt` = 0. Any beat presented in the reset cycle is discarded.

## Timing
- **Latency.** A beat presented in cycle N appears on the output port in cycle N+2: FIFO write at the end of N, pop and output register at the end of N+1.
- **Throughput.** One output beat per cycle in aggregate. Each requester may push one beat per cycle.
- **Simultaneous push and pop on one FIFO.** Legal when the FIFO is full. The pop frees the slot, so the push succeeds and no overflow occurs.
- **Almost-full flags.** Registered and computed from next occupancy: asserted in cycle N+1 when the push in cycle N reaches AFULL_THRESH. Upstream headroom is FIFO_DEPTH − AFULL_THRESH beats.
- **Occupancy pointers.** Wrap modulo FIFO_DEPTH. Occupancy is a clog2(FIFO_DEPTH)+1 bit counter.
- **Starvation bound.** With both requesters continuously backlogged, grants alternate in runs of exactly MAX_BURST. No requester waits more than MAX_BURST cycles.

## Configuration
- `PCIE_RX_WR_ARB_STATS_EN` defined:
  - `stat_grant_wr` / `stat_grant_cm` increment on each pop of that requester.
  - `stat_ovf_cnt` increments once per dropped beat (by 2 if both requesters drop in the same cycle).
  - All three counters wrap at 2^32.
- Undefined: the three `stat_*` outputs are constant 0 and the counter logic is not synthesized. `ovf_*` flags exist in both builds.

## Test plan
- **Single beat:** push one wr beat, addr_lo = 0x10, data_lo = 0xDEADBEEF, en_lo only -> output shows that beat with en_lo = 1, en_hi = 0 exactly 2 cycles later, then en = 0.
- **Both backlogged:** both requesters push 8 beats back-to-back, MAX_BURST = 4 -> output order is wr×4, cm×4, wr×4, cm×4. No gaps after the first beat; no overflow.
- **Fill and overflow:** cm pushes 10 beats while wr pushes continuously (DEPTH 8) -> cm beats drain in order. `wr_afull_cm` rises the cycle after occupancy reaches 6. A later run that exceeds capacity drops beats, sets `ovf_cm` = 1, and `stat_ovf_cnt` equals the number of dropped beats.
- **Full FIFO, simultaneous push and pop:** push into a full FIFO in the same cycle as a pop -> beat accepted, `ovf` stays 0.
- **Reset mid-burst:** assert `rst` for 1 cycle with 5 beats queued -> all outputs 0 the next cycle, no queued beat is ever emitted, counters 0, and the first post-reset push appears 2 cycles later.
- **Stats build:** with `PCIE_RX_WR_ARB_STATS_EN` undefined, rerun the both-backlogged scenario -> `stat_*` outputs remain 0 throughout.

Source files
------------

// File: rtl/pcie_rx_wr_arb.sv
// pcie_rx_wr_arb: shared memory write-port arbiter for the PCIe receive path, with per-requester beat FIFOs.
// Optional statistics counters are built when PCIE_RX_WR_ARB_STATS_EN is defined.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module pcie_rx_wr_arb #(
  parameter int unsigned ADDR_W       = `MEM_ADDR_BITS,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned AFULL_THRESH = 6,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic              pcie_clk,
  input  logic              rst,
  input  logic [1:0]        wr_if_select_wr,
  input  logic [1:0]        wr_if_select_cm,
  input  logic [3:0]        wr_mem_select_wr,
  input  logic [3:0]        wr_mem_select_cm,
  input  logic [ADDR_W-1:0] wr_addr_hi_wr,
  input  logic [ADDR_W-1:0] wr_addr_hi_cm,
  input  logic [ADDR_W-1:0] wr_addr_lo_wr,
  input  logic [ADDR_W-1:0] wr_addr_lo_cm,
  input  logic [31:0]       wr_data_hi_wr,
  input  logic [31:0]       wr_data_hi_cm,
  input  logic [31:0]       wr_data_lo_wr,
  input  logic [31:0]       wr_data_lo_cm,
  input  logic [3:0]        wr_mask_hi_wr,
  input  logic [3:0]        wr_mask_hi_cm,
  input  logic [3:0]        wr_mask_lo_wr,
  input  logic [3:0]        wr_mask_lo_cm,
  input  logic              wr_en_hi_wr,
  input  logic              wr_en_hi_cm,
  input  logic              wr_en_lo_wr,
  input  logic              wr_en_lo_cm,
  output logic              wr_afull_wr,
  output logic              wr_afull_cm,
  output logic [1:0]        wr_if_select,
  output logic [3:0]        wr_mem_select,
  output logic [ADDR_W-1:0] wr_addr_hi,
  output logic [ADDR_W-1:0] wr_addr_lo,
  output logic [31:0]       wr_data_hi,
  output logic [31:0]       wr_data_lo,
  output logic [3:0]        wr_mask_hi,
  output logic [3:0]        wr_mask_lo,
  output logic              wr_en_hi,
  output logic              wr_en_lo,
  output logic              ovf_wr,
  output logic              ovf_cm,
  output logic [31:0]       stat_grant_wr,
  output logic [31:0]       stat_grant_cm,
  output logic [31:0]       stat_ovf_cnt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = $clog2(MAX_BURST) + 1;

  typedef struct packed {
    logic [1:0]        if_sel;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] addr_hi;
    logic [ADDR_W-1:0] addr_lo;
    logic [31:0]       data_hi;
    logic [31:0]       data_lo;
    logic [3:0]        mask_hi;
    logic [3:0]        mask_lo;
    logic              en_hi;
    logic              en_lo;
  } beat_t;

  // Index 0 is the posted-write requester, index 1 the completion requester.
  beat_t             w_in      [2];
  logic [1:0]        w_valid;
  beat_t             r_mem     [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp      [2];
  logic [PTR_W-1:0]  r_rp      [2];
  logic [OCC_W-1:0]  r_occ     [2];
  logic [OCC_W-1:0]  w_occ_nxt [2];
  logic [1:0]        w_ne;
  logic [1:0]        w_full;
  logic [1:0]        w_acc;
  logic [1:0]        w_drop;
  logic [1:0]        w_pop;
  logic [1:0]        r_afull;
  logic [1:0]        r_ovf;
  logic              r_grant;
  logic              w_grant_nxt;
  logic [BCNT_W-1:0] r_bcnt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic [BCNT_W-1:0] w_bcnt_inc;
  beat_t             w_head;
  beat_t             r_out;

  assign w_in[0] = {wr_if_select_wr, wr_mem_select_wr, wr_addr_hi_wr, wr_addr_lo_wr,
                    wr_data_hi_wr, wr_data_lo_wr, wr_mask_hi_wr, wr_mask_lo_wr,
                    wr_en_hi_wr, wr_en_lo_wr};
  assign w_in[1] = {wr_if_select_cm, wr_mem_select_cm, wr_addr_hi_cm, wr_addr_lo_cm,
                    wr_data_hi_cm, wr_data_lo_cm, wr_mask_hi_cm, wr_mask_lo_cm,
                    wr_en_hi_cm, wr_en_lo_cm};

  // A beat presented while rst is high never reaches a FIFO.
  assign w_valid[0] = ~rst & (wr_en_hi_wr | wr_en_lo_wr);
  assign w_valid[1] = ~rst & (wr_en_hi_cm | wr_en_lo_cm);

  // FIFO status from registered occupancy.
  always_comb begin
    w_ne   = '0;
    w_full = '0;
    for (int i = 0; i < 2; i++) begin
      w_ne[i]   = (r_occ[i] != '0);
      w_full[i] = (r_occ[i] == OCC_W'(FIFO_DEPTH));
    end
  end

  // Round-robin scheduler with burst limit.
  always_comb begin
    w_pop       = '0;
    w_grant_nxt = r_grant;
    w_bcnt_nxt  = r_bcnt;
    w_bcnt_inc  = (r_bcnt >= BCNT_W'(MAX_BURST)) ? BCNT_W'(MAX_BURST) : r_bcnt + 1'b1;
    if (w_ne == 2'b11) begin
      if (r_bcnt < BCNT_W'(MAX_BURST)) begin
        w_pop[r_grant] = 1'b1;
        w_bcnt_nxt     = r_bcnt + 1'b1;
      end else begin
        w_grant_nxt        = ~r_grant;
        w_pop[w_grant_nxt] = 1'b1;
        w_bcnt_nxt         = BCNT_W'(1);
      end
    end else if (w_ne != 2'b00) begin
      w_pop       = w_ne;
      w_grant_nxt = w_ne[1];
      w_bcnt_nxt  = (w_ne[1] != r_grant) ? BCNT_W'(1) : w_bcnt_inc;
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  always_comb begin
    w_acc  = '0;
    w_drop = '0;
    for (int i = 0; i < 2; i++) begin
      w_acc[i]     = w_valid[i] & (~w_full[i] | w_pop[i]);
      w_drop[i]    = w_valid[i] & w_full[i] & ~w_pop[i];
      w_occ_nxt[i] = r_occ[i] + OCC_W'(w_acc[i]) - OCC_W'(w_pop[i]);
    end
  end

  assign w_head = r_mem[w_grant_nxt][r_rp[w_grant_nxt]];

  // Beat storage carries no reset; pointers and occupancy define validity.
  always_ff @(posedge pcie_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_acc[i]) begin
        r_mem[i][r_wp[i]] <= w_in[i];
      end
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_occ[i] <= '0;
      end
      r_afull <= '0;
      r_ovf   <= '0;
      r_grant <= 1'b0;
      r_bcnt  <= '0;
      r_out   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_acc[i]) begin
          r_wp[i] <= r_wp[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rp[i] <= r_rp[i] + 1'b1;
        end
        r_occ[i]   <= w_occ_nxt[i];
        r_afull[i] <= (w_occ_nxt[i] >= OCC_W'(AFULL_THRESH));
        if (w_drop[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
      r_grant <= w_grant_nxt;
      r_bcnt  <= w_bcnt_nxt;
      // Idle cycles only drop the enables; the rest of the port holds.
      if (w_pop != 2'b00) begin
        r_out <= w_head;
      end else begin
        r_out.en_hi <= 1'b0;
        r_out.en_lo <= 1'b0;
      end
    end
  end

  assign wr_afull_wr   = r_afull[0];
  assign wr_afull_cm   = r_afull[1];
  assign ovf_wr        = r_ovf[0];
  assign ovf_cm        = r_ovf[1];
  assign wr_if_select  = r_out.if_sel;
  assign wr_mem_select = r_out.mem_sel;
  assign wr_addr_hi    = r_out.addr_hi;
  assign wr_addr_lo    = r_out.addr_lo;
  assign wr_data_hi    = r_out.data_hi;
  assign wr_data_lo    = r_out.data_lo;
  assign wr_mask_hi    = r_out.mask_hi;
  assign wr_mask_lo    = r_out.mask_lo;
  assign wr_en_hi      = r_out.en_hi;
  assign wr_en_lo      = r_out.en_lo;

`ifdef PCIE_RX_WR_ARB_STATS_EN
  logic [31:0] r_stat_gwr;
  logic [31:0] r_stat_gcm;
  logic [31:0] r_stat_ovf;

  // Free-running counters, wrapping at 2^32.
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      r_stat_gwr <= '0;
      r_stat_gcm <= '0;
      r_stat_ovf <= '0;
    end else begin
      r_stat_gwr <= r_stat_gwr + 32'(w_pop[0]);
      r_stat_gcm <= r_stat_gcm + 32'(w_pop[1]);
      r_stat_ovf <= r_stat_ovf + 32'(w_drop[0]) + 32'(w_drop[1]);
    end
  end

  assign stat_grant_wr = r_stat_gwr;
  assign stat_grant_cm = r_stat_gcm;
  assign stat_ovf_cnt  = r_stat_ovf;
`else
  assign stat_grant_wr = '0;
  assign stat_grant_cm = '0;
  assign stat_ovf_cnt  = '0;
`endif

endmodule
